// File: rtl/select_scan_ctrl_if.sv
// Host-side handshake and result bus of select_scan_ctrl.
//   start, abort : host -> controller requests
//   busy, done   : scan status (done is a one-cycle completion pulse)
//   pattern      : captured 16-entry truth table
//   match        : pattern equals the golden table, valid from done onward
//   first_fail   : lowest mismatching vector index, 0 when match is set
interface select_scan_ctrl_if;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] pattern;
  logic        match;
  logic [3:0]  first_fail;

  modport master (
    output start, abort,
    input  busy, done, pattern, match, first_fail
  );

  modport slave (
    input  start, abort,
    output busy, done, pattern, match, first_fail
  );
endinterface

// File: rtl/select_scan_ctrl.sv
// Self-test sequencer for the gate-level selector circuit. Steps the vector
// {s2,s1,s0,i} through 0..15, holds each for SETTLE+1 cycles, samples y into
// a truth-table register and compares the finished table against GOLDEN.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : start/abort requests, busy/done status, results
//   y               : output of the circuit under control
//   s2, s1, s0, i   : vector driven to the circuit, equal to idx
//
// state  | meaning
// IDLE   | waiting for start, vector parked at 0
// SETTLE | current vector held while cnt counts down to 1
// SAMPLE | y captured into pattern[idx], advance or finish
// FINISH | one-cycle done pulse, match/first_fail already valid
module select_scan_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter logic [15:0] GOLDEN = 16'h0810
) (
  input  logic              clk,
  input  logic              rst_n,
  select_scan_ctrl_if.slave bus,
  input  logic              y,
  output logic              s2,
  output logic              s1,
  output logic              s0,
  output logic              i
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE_ST = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [15:0] pattern, pattern_nx;
  logic        match, match_nx;
  logic [3:0]  first_fail, first_fail_nx;
  logic        busy, busy_nx;
  logic        done, done_nx;

  // Table with the bit currently being sampled merged in, so the final
  // compare sees vector 15 in the same cycle it is captured.
  logic [15:0] pat_smp;
  logic [15:0] diff;
  logic [3:0]  ff_enc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 4'd0;
      cnt        <= 4'd0;
      pattern    <= 16'h0000;
      match      <= 1'b0;
      first_fail <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      pattern    <= pattern_nx;
      match      <= match_nx;
      first_fail <= first_fail_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    cnt_nx        = cnt;
    pattern_nx    = pattern;
    match_nx      = match;
    first_fail_nx = first_fail;

    pat_smp      = pattern;
    pat_smp[idx] = y;
    diff         = pat_smp ^ GOLDEN;
    ff_enc       = 4'd0;
    // Scan downward so the lowest mismatching index is the one left standing.
    for (int n = 15; n >= 0; n--) begin
      if (diff[n]) ff_enc = 4'(n);
    end

    case (state)
      IDLE: begin
        idx_nx = 4'd0;
        if (bus.start) begin
          pattern_nx = 16'h0000;
          cnt_nx     = SETTLE_CNT;
          state_nx   = SETTLE_ST;
        end
      end
      SETTLE_ST: begin
        if (bus.abort) begin
          idx_nx   = 4'd0;
          state_nx = IDLE;
        end else if (cnt == 4'd1) begin
          state_nx = SAMPLE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          idx_nx   = 4'd0;
          state_nx = IDLE;
        end else begin
          pattern_nx = pat_smp;
          if (idx != 4'd15) begin
            idx_nx   = idx + 4'd1;
            cnt_nx   = SETTLE_CNT;
            state_nx = SETTLE_ST;
          end else begin
            match_nx      = (diff == 16'h0000);
            first_fail_nx = ff_enc;
            state_nx      = FINISH;
          end
        end
      end
      FINISH: begin
        idx_nx   = 4'd0;
        state_nx = IDLE;
      end
      default: begin
        idx_nx   = 4'd0;
        state_nx = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up
    // exactly with the state they describe.
    busy_nx = (state_nx == SETTLE_ST) || (state_nx == SAMPLE);
    done_nx = (state_nx == FINISH);
  end

  assign {s2, s1, s0, i} = idx;

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pattern    = pattern;
  assign bus.match      = match;
  assign bus.first_fail = first_fail;

endmodule

// File: tb/tb_select_scan_ctrl.sv
module tb_select_scan_ctrl;

  typedef struct {
    logic [15:0] pat;
    logic        m;
    logic [3:0]  ff;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt1 = 0;
  int   done_cnt2 = 0;
  int   k;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  select_scan_ctrl_if bus1 ();
  select_scan_ctrl_if bus2 ();

  logic s2_1, s1_1, s0_1, i_1, y1;
  logic s2_2, s1_2, s0_2, i_2, y2;
  logic [3:0] v1, v2;
  logic [1:0] mode1;

  assign v1 = {s2_1, s1_1, s0_1, i_1};
  assign v2 = {s2_2, s1_2, s0_2, i_2};
  // mode 0: golden circuit (y high for vectors 4 and 11), 1: stuck 0, 2: stuck 1
  assign y1 = (mode1 == 2'd0) ? ((v1 == 4'd4) || (v1 == 4'd11)) :
              (mode1 == 2'd1) ? 1'b0 : 1'b1;
  assign y2 = i_2;

  select_scan_ctrl #(.SETTLE(2), .GOLDEN(16'h0810)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .y(y1),
    .s2(s2_1), .s1(s1_1), .s0(s0_1), .i(i_1)
  );

  select_scan_ctrl #(.SETTLE(1), .GOLDEN(16'h0810)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .y(y2),
    .s2(s2_2), .s1(s1_2), .s0(s0_2), .i(i_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus1.done) begin
      done_cnt1++;
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done1_unexpected: got done at cycle %0d expected none", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("done1_pattern", 32'(bus1.pattern), 32'(e1.pat));
        chk("done1_match", 32'(bus1.match), 32'(e1.m));
        chk("done1_first_fail", 32'(bus1.first_fail), 32'(e1.ff));
        chk("done1_cycle", 32'(cyc), 32'(e1.cyc));
        chk("done1_busy", 32'(bus1.busy), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus2.done) begin
      done_cnt2++;
      if (q2.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done2_unexpected: got done at cycle %0d expected none", cyc);
      end else begin
        e2 = q2.pop_front();
        chk("done2_pattern", 32'(bus2.pattern), 32'(e2.pat));
        chk("done2_match", 32'(bus2.match), 32'(e2.m));
        chk("done2_first_fail", 32'(bus2.first_fail), 32'(e2.ff));
        chk("done2_cycle", 32'(cyc), 32'(e2.cyc));
        chk("done2_busy", 32'(bus2.busy), 32'd0);
      end
    end
  end

  task automatic wait_q1(input int budget);
    for (int b = 0; b < budget && q1.size() != 0; b++) @(negedge clk);
    if (q1.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL wait_done1: got no done within %0d cycles expected done", budget);
      q1.delete();
    end
  endtask

  task automatic wait_q2(input int budget);
    for (int b = 0; b < budget && q2.size() != 0; b++) @(negedge clk);
    if (q2.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL wait_done2: got no done within %0d cycles expected done", budget);
      q2.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vec"}, 32'(v1), 32'd0);
    chk({tag, "_busy"}, 32'(bus1.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus1.done), 32'd0);
    chk({tag, "_pattern"}, 32'(bus1.pattern), 32'd0);
    chk({tag, "_match"}, 32'(bus1.match), 32'd0);
    chk({tag, "_first_fail"}, 32'(bus1.first_fail), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    bus2.start = 1'b0;
    bus2.abort = 1'b0;
    mode1 = 2'd0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Golden scan, SETTLE=2: vector steps 0..15, 3 cycles each, done at +48.
    mode1 = 2'd0;
    q1.push_back('{16'h0810, 1'b1, 4'd0, cyc + 1 + 48});
    bus1.start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    bus1.start = 1'b0;
    chk("golden_busy_first", 32'(bus1.busy), 32'd1);
    for (int t = 0; t < 48; t++) begin
      chk("golden_vec", 32'(v1), 32'(t / 3));
      @(negedge clk);
    end
    @(negedge clk);
    chk("golden_vec_return", 32'(v1), 32'd0);
    chk("golden_busy_after", 32'(bus1.busy), 32'd0);
    wait_q1(10);

    // Reset mid-scan while vector 9 is driven.
    bus1.start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (27) @(negedge clk);
    chk("rst_pre_vec", 32'(v1), 32'd9);
    chk("rst_pre_match", 32'(bus1.match), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_idle_busy", 32'(bus1.busy), 32'd0);
    chk("rst_idle_vec", 32'(v1), 32'd0);

    // Stuck-at-0, with starts pulsed while busy and in the FINISH cycle.
    mode1 = 2'd1;
    q1.push_back('{16'h0000, 1'b0, 4'd4, cyc + 1 + 48});
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int t = 0; t < 48; t++) begin
      bus1.start = (t == 10);
      @(negedge clk);
    end
    chk("stuck0_done_seen", 32'(bus1.done), 32'd1);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    chk("finish_start_ignored", 32'(bus1.busy), 32'd0);
    wait_q1(10);
    repeat (3) @(negedge clk);

    // y = i on the SETTLE=1 instance: 32-cycle scan, table 16'hAAAA.
    q2.push_back('{16'hAAAA, 1'b0, 4'd1, cyc + 1 + 32});
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    wait_q2(50);
    repeat (2) @(negedge clk);

    // Abort in SAMPLE at idx 7 with y stuck high: bit 7 must stay clear.
    mode1 = 2'd2;
    bus1.start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (23) @(negedge clk);
    chk("abort_pre_vec", 32'(v1), 32'd7);
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.abort = 1'b0;
    chk("abort_busy", 32'(bus1.busy), 32'd0);
    chk("abort_vec", 32'(v1), 32'd0);
    chk("abort_done", 32'(bus1.done), 32'd0);
    chk("abort_pattern", 32'(bus1.pattern), 32'h007F);
    chk("abort_match_hold", 32'(bus1.match), 32'd0);
    chk("abort_ff_hold", 32'(bus1.first_fail), 32'd4);
    q1.push_back('{16'hFFFF, 1'b0, 4'd0, cyc + 1 + 48});
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    chk("restart_busy", 32'(bus1.busy), 32'd1);
    chk("restart_pattern_clr", 32'(bus1.pattern), 32'd0);
    chk("restart_ff_hold", 32'(bus1.first_fail), 32'd4);
    wait_q1(60);
    repeat (3) @(negedge clk);

    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("done_count1", 32'(done_cnt1), 32'd3);
    chk("done_count2", 32'(done_cnt2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
